// File: rtl/guess_pkg.sv
// guess_pkg: shared constants, digit types, FSM state enum and small helpers
// for the number-guessing score engine.
`default_nettype none

package guess_pkg;

  localparam int DIGITS    = 4;
  localparam int DIGIT_W   = 4;
  localparam int MAX_DIGIT = 9;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef digit_t [DIGITS-1:0] digit_vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Position 0 lives in the least significant nibble.
  function automatic digit_vec_t unpack_digits(input logic [DIGITS*DIGIT_W-1:0] word);
    digit_vec_t d;
    for (int k = 0; k < DIGITS; k++) begin
      d[k] = word[k*DIGIT_W +: DIGIT_W];
    end
    return d;
  endfunction

  function automatic logic [2:0] count_ones(input logic [DIGITS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < DIGITS; k++) begin
      n = n + 3'(v[k]);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/guess_judge_if.sv
// guess_judge_if: request/result bundle between the game controller (master)
// and the scoring engine (slave).
`default_nettype none

interface guess_judge_if #(
  parameter int TRY_W = 4
);

  logic             submit;
  logic             new_game;
  logic [15:0]      q_digits;
  logic [15:0]      a_digits;
  logic             busy;
  logic             result_valid;
  logic [2:0]       count_a;
  logic [2:0]       count_b;
  logic             win;
  logic             game_over;
  logic [TRY_W-1:0] tries;
  logic             invalid;

  modport master (
    output submit, new_game, q_digits, a_digits,
    input  busy, result_valid, count_a, count_b, win, game_over, tries, invalid
  );

  modport slave (
    input  submit, new_game, q_digits, a_digits,
    output busy, result_valid, count_a, count_b, win, game_over, tries, invalid
  );

endinterface

`default_nettype wire

// File: rtl/guess_scan_ctr.sv
// guess_scan_ctr: nested 2-bit (i, j) scan counter; j is the fast index and
// last flags the final (3,3) step while advancing.
`default_nettype none

module guess_scan_ctr (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       start,
  input  logic       advance,
  output logic [1:0] i,
  output logic [1:0] j,
  output logic       last
);

  always_ff @(posedge clock) begin
    if (!reset_n || clear || start) begin
      i <= 2'd0;
      j <= 2'd0;
    end else if (advance) begin
      {i, j} <= {i, j} + 4'd1;
    end
  end

  assign last = advance && (i == 2'd3) && (j == 2'd3);

endmodule

`default_nettype wire

// File: rtl/guess_judge.sv
// guess_judge: bulls/cows scorer with attempt, win and game-over tracking.
// Optional answer-digit range check enabled by GUESS_JUDGE_DIGIT_CHECK_EN.
`default_nettype none

module guess_judge
  import guess_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  guess_judge_if.slave  bus
);

  localparam logic [TRY_W-1:0] TRIES_CAP = TRY_W'(MAX_TRIES);

  state_t           state;
  state_t           state_next;
  logic             busy;
  logic             accept;
  logic             scanning;
  logic             finishing;
  logic [1:0]       scan_i;
  logic [1:0]       scan_j;
  logic             scan_last;
  digit_vec_t       q_snap;
  digit_vec_t       a_snap;
  logic [DIGITS-1:0] hit_a;
  logic [DIGITS-1:0] hit_b;
  logic [2:0]       pop_a;
  logic [2:0]       pop_b;
  logic [TRY_W-1:0] tries_inc;
  logic             bad_digit;

  logic             valid_pulse;
  logic             invalid_pulse;
  logic [2:0]       cnt_a;
  logic [2:0]       cnt_b;
  logic [TRY_W-1:0] tries_cnt;
  logic             win_flag;
  logic             over_flag;

  guess_scan_ctr u_scan_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bus.new_game),
    .start   (accept),
    .advance (scanning),
    .i       (scan_i),
    .j       (scan_j),
    .last    (scan_last)
  );

  always_ff @(posedge clock) begin
    if (!reset_n || bus.new_game) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.submit && !over_flag) state_next = SCAN;
      SCAN:    if (scan_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    scanning  = 1'b0;
    finishing = 1'b0;
    case (state)
      IDLE:    accept    = bus.submit && !over_flag && !bus.new_game;
      SCAN:    begin
                 busy     = 1'b1;
                 scanning = 1'b1;
               end
      DONE:    finishing = 1'b1;
      default: ;
    endcase
  end

  // A position already counted as exact never also counts as misplaced.
  assign pop_a     = count_ones(hit_a);
  assign pop_b     = count_ones(hit_b & ~hit_a);
  assign tries_inc = (tries_cnt == TRIES_CAP) ? tries_cnt : tries_cnt + TRY_W'(1);

`ifdef GUESS_JUDGE_DIGIT_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a_snap[k] > digit_t'(MAX_DIGIT)) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n || bus.new_game) begin
      q_snap        <= '0;
      a_snap        <= '0;
      hit_a         <= '0;
      hit_b         <= '0;
      valid_pulse   <= 1'b0;
      invalid_pulse <= 1'b0;
      cnt_a         <= 3'd0;
      cnt_b         <= 3'd0;
      tries_cnt     <= '0;
      win_flag      <= 1'b0;
      over_flag     <= 1'b0;
    end else begin
      valid_pulse   <= 1'b0;
      invalid_pulse <= 1'b0;
      if (accept) begin
        q_snap <= unpack_digits(bus.q_digits);
        a_snap <= unpack_digits(bus.a_digits);
        hit_a  <= '0;
        hit_b  <= '0;
      end
      if (scanning && (a_snap[scan_i] == q_snap[scan_j])) begin
        if (scan_i == scan_j) hit_a[scan_i] <= 1'b1;
        else                  hit_b[scan_i] <= 1'b1;
      end
      if (finishing) begin
        valid_pulse <= 1'b1;
        if (bad_digit) begin
          invalid_pulse <= 1'b1;
          cnt_a         <= 3'd0;
          cnt_b         <= 3'd0;
        end else begin
          cnt_a     <= pop_a;
          cnt_b     <= pop_b;
          tries_cnt <= tries_inc;
          if (pop_a == 3'd4) win_flag <= 1'b1;
          if ((pop_a == 3'd4) || (tries_inc == TRIES_CAP)) over_flag <= 1'b1;
        end
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.result_valid = valid_pulse;
  assign bus.invalid      = invalid_pulse;
  assign bus.count_a      = cnt_a;
  assign bus.count_b      = cnt_b;
  assign bus.tries        = tries_cnt;
  assign bus.win          = win_flag;
  assign bus.game_over    = over_flag;

endmodule

`default_nettype wire

// File: tb/tb_guess_judge.sv
// tb_guess_judge: directed and randomized scoring checks against a
// position-by-position bulls/cows reference model.
`default_nettype none

module tb_guess_judge;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  int   m_a, m_b, m_tries;
  bit   m_win, m_over;

  guess_judge_if #(.TRY_W(4)) bus ();

  guess_judge #(.MAX_TRIES(10), .TRY_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_tries = 0; m_win = 0; m_over = 0;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),         0);
    chk({tag, "_rv"},     32'(bus.result_valid), 0);
    chk({tag, "_a"},      32'(bus.count_a),      0);
    chk({tag, "_b"},      32'(bus.count_b),      0);
    chk({tag, "_tries"},  32'(bus.tries),        0);
    chk({tag, "_win"},    32'(bus.win),          0);
    chk({tag, "_over"},   32'(bus.game_over),    0);
    chk({tag, "_inv"},    32'(bus.invalid),      0);
  endtask

  // Bulls: equal digit at the same position. Cows: any other answer position
  // whose digit occurs elsewhere in the question (each answer position once).
  function automatic void ref_score(input logic [15:0] q, input logic [15:0] a,
                                    output int ca, output int cb, output bit bad);
    ca = 0; cb = 0; bad = 0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] ai;
      bit found;
      ai = a[4*i +: 4];
      found = 0;
      if (ai > 4'd9) bad = 1;
      if (ai == q[4*i +: 4]) ca++;
      else begin
        for (int j = 0; j < 4; j++)
          if (j != i && ai == q[4*j +: 4]) found = 1;
        if (found) cb++;
      end
    end
  endfunction

  function automatic logic [15:0] rand_digits(input bit hex);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) begin
      if (hex && $urandom_range(0, 9) == 0) r[4*k +: 4] = 4'($urandom_range(10, 15));
      else                                 r[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return r;
  endfunction

  task automatic no_result_window(input string tag, input int cycles);
    bit saw;
    saw = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock); #1;
      if (bus.result_valid) saw = 1;
    end
    chk({tag, "_no_rv"}, 32'(saw), 0);
  endtask

  task automatic play(input string tag, input logic [15:0] q, input logic [15:0] a);
    int ea, eb, lat;
    bit bad, accept;
    accept = !m_over;
    ref_score(q, a, ea, eb, bad);
`ifndef GUESS_JUDGE_DIGIT_CHECK_EN
    bad = 0;
`endif
    @(negedge clock);
    bus.submit = 1; bus.q_digits = q; bus.a_digits = a;
    @(posedge clock);
    @(negedge clock);
    bus.submit = 0;
    bus.q_digits = 16'($urandom);
    bus.a_digits = 16'($urandom);
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock); #1;
      if (bus.result_valid) begin
        lat = n;
        break;
      end
    end
    if (accept) begin
      if (bad) begin
        m_a = 0; m_b = 0;
      end else begin
        m_a = ea; m_b = eb;
        m_tries = (m_tries < 10) ? m_tries + 1 : 10;
        if (ea == 4) m_win = 1;
        if (m_win || m_tries == 10) m_over = 1;
      end
      chk({tag, "_latency"}, 32'(lat), 17);
      chk({tag, "_inv"},   32'(bus.invalid),   32'(bad));
    end else begin
      chk({tag, "_ignored"}, 32'(lat), 0);
    end
    chk({tag, "_a"},     32'(bus.count_a),   32'(m_a));
    chk({tag, "_b"},     32'(bus.count_b),   32'(m_b));
    chk({tag, "_tries"}, 32'(bus.tries),     32'(m_tries));
    chk({tag, "_win"},   32'(bus.win),       32'(m_win));
    chk({tag, "_over"},  32'(bus.game_over), 32'(m_over));
    if (accept) begin
      @(posedge clock); #1;
      chk({tag, "_pulse_end"}, 32'(bus.result_valid), 0);
    end
  endtask

  task automatic pulse_new_game(input string tag);
    @(negedge clock);
    bus.new_game = 1;
    @(posedge clock); #1;
    chk_cleared(tag);
    @(negedge clock);
    bus.new_game = 0;
    model_clear();
  endtask

  initial begin
    bus.submit = 0; bus.new_game = 0; bus.q_digits = '0; bus.a_digits = '0;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    chk_cleared("reset");
    @(negedge clock);
    reset_n = 1;

    play("two_two", 16'h4321, 16'h3421);
    chk("two_two_a_const", 32'(bus.count_a), 2);
    chk("two_two_b_const", 32'(bus.count_b), 2);
    play("ones", 16'h4321, 16'h1111);
    chk("ones_a_const", 32'(bus.count_a), 1);
    chk("ones_b_const", 32'(bus.count_b), 3);
    play("none", 16'h4321, 16'h8765);
    chk("none_a_const", 32'(bus.count_a), 0);
    play("win", 16'h4321, 16'h4321);
    chk("win_const", 32'(bus.win), 1);
    chk("win_over_const", 32'(bus.game_over), 1);
    play("after_win", 16'h4321, 16'h1111);

    pulse_new_game("ng1");
    play("hex", 16'h4321, 16'hA321);

    pulse_new_game("ng2");
    for (int t = 0; t < 10; t++) play("ten", 16'h4321, 16'h8765);
    chk("ten_tries_const", 32'(bus.tries), 10);
    chk("ten_over_const", 32'(bus.game_over), 1);
    play("eleventh", 16'h4321, 16'h8765);

    pulse_new_game("ng3");
    play("pre_abort", 16'h4321, 16'h1234);
    @(negedge clock);
    bus.submit = 1; bus.a_digits = 16'h4321; bus.q_digits = 16'h4321;
    @(posedge clock);
    @(negedge clock);
    bus.submit = 0;
    repeat (4) @(negedge clock);
    chk("abort_busy", 32'(bus.busy), 1);
    bus.new_game = 1;
    @(posedge clock); #1;
    chk_cleared("abort");
    @(negedge clock);
    bus.new_game = 0;
    model_clear();
    no_result_window("abort", 25);

    @(negedge clock);
    bus.submit = 1; bus.new_game = 1;
    @(posedge clock); #1;
    chk("same_cycle_busy", 32'(bus.busy), 0);
    @(negedge clock);
    bus.submit = 0; bus.new_game = 0;
    no_result_window("same_cycle", 25);

    play("pre_rst", 16'h4321, 16'h1243);
    @(negedge clock);
    bus.submit = 1;
    @(posedge clock);
    @(negedge clock);
    bus.submit = 0;
    repeat (4) @(negedge clock);
    reset_n = 0;
    @(posedge clock); #1;
    chk_cleared("mid_rst");
    @(negedge clock);
    reset_n = 1;
    model_clear();
    no_result_window("mid_rst", 25);

    for (int g = 0; g < 3; g++) begin
      pulse_new_game("rnd_ng");
      for (int t = 0; t < 12; t++) begin
        logic [15:0] q, a;
        q = rand_digits(0);
        a = ($urandom_range(0, 5) == 0) ? q : rand_digits(1);
        play("rnd", q, a);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
